// File: rtl/noc_pkg.sv
// Shared NoC constants: flit width, flit-type encoding and type-field position.
package noc_pkg;

  localparam int unsigned FLIT_W  = 34;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned TYPE_HI = FLIT_W - 1;
  localparam int unsigned TYPE_LO = FLIT_W - TYPE_W;

  typedef enum logic [1:0] {
    FT_HEAD   = 2'b00,
    FT_BODY   = 2'b01,
    FT_SINGLE = 2'b10,
    FT_TAIL   = 2'b11
  } flit_type_t;

  localparam flit_type_t HEAD   = FT_HEAD;
  localparam flit_type_t BODY   = FT_BODY;
  localparam flit_type_t TAIL   = FT_TAIL;
  localparam flit_type_t SINGLE = FT_SINGLE;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_IN_PKT = 1'b1
  } vc_state_t;

endpackage

// File: rtl/vc_out_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: first requester after the last winner, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned LAST_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]      req_i,
  input  logic [LAST_W-1:0] last_i,
  output logic [N-1:0]      gnt_c
);

  logic [LAST_W-1:0] idx;
  logic              found;

  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = LAST_W'((32'(last_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_c[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_out_arbiter.sv
// Flit-level round-robin VC output arbiter with per-VC framing check.
// VC_OUT_CREDIT_FC_EN swaps ready_i backpressure for per-VC credit counters.
module vc_out_arbiter
  import noc_pkg::*;
#(
`ifdef VC_OUT_CREDIT_FC_EN
  parameter int unsigned BUF_DEPTH = 2,
`endif
  parameter int unsigned N_VC   = 3,
  parameter int unsigned FLIT_W = noc_pkg::FLIT_W
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_VC*FLIT_W-1:0]   vc_fdata_i,
  input  logic [N_VC-1:0]          vc_valid_i,
  output logic [N_VC-1:0]          vc_ready_o,
  output logic [FLIT_W-1:0]        fdata_o,
  output logic [1:0]               vc_id_o,
  output logic                     valid_o,
`ifdef VC_OUT_CREDIT_FC_EN
  input  logic [N_VC-1:0]          credit_i,
`else
  input  logic                     ready_i,
`endif
  output logic                     proto_err_o
);

  localparam int unsigned PTR_W = (N_VC > 1) ? $clog2(N_VC) : 1;

  logic [N_VC-1:0]   eligible_c;
  logic [N_VC-1:0]   gnt_c;
  logic              accept_c;
  logic              load_c;
  logic [PTR_W-1:0]  gidx_c;
  logic [FLIT_W-1:0] gflit_c;
  flit_type_t        gtype_c;

  logic [FLIT_W-1:0] fdata_q;
  logic [1:0]        vc_id_q;
  logic              valid_q;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  rr_ptr_q;
  vc_state_t         st_q [N_VC];
  vc_state_t         st_d [N_VC];

`ifdef VC_OUT_CREDIT_FC_EN
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  logic [CNT_W-1:0] cnt_q [N_VC];

  always_comb begin
    for (int unsigned v = 0; v < N_VC; v++) begin
      eligible_c[v] = vc_valid_i[v] && (cnt_q[v] != '0);
    end
  end
  assign accept_c = 1'b1;

  // Downstream buffer credits: spend on load, refill on credit_i, saturate at depth.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int unsigned v = 0; v < N_VC; v++) cnt_q[v] <= CNT_W'(BUF_DEPTH);
    end else begin
      for (int unsigned v = 0; v < N_VC; v++) begin
        if (vc_ready_o[v] && !credit_i[v]) begin
          cnt_q[v] <= cnt_q[v] - CNT_W'(1);
        end else if (credit_i[v] && !vc_ready_o[v] && (cnt_q[v] != CNT_W'(BUF_DEPTH))) begin
          cnt_q[v] <= cnt_q[v] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign eligible_c = vc_valid_i;
  assign accept_c   = !valid_q || ready_i;
`endif

  rr_arbiter #(.N(N_VC)) u_rr (
    .req_i  (eligible_c),
    .last_i (rr_ptr_q),
    .gnt_c  (gnt_c)
  );

  assign load_c     = accept_c && (|eligible_c);
  assign vc_ready_o = load_c ? gnt_c : '0;

  // Winner index and its flit.
  always_comb begin
    gidx_c  = '0;
    gflit_c = '0;
    for (int unsigned v = 0; v < N_VC; v++) begin
      if (gnt_c[v]) begin
        gidx_c  = PTR_W'(v);
        gflit_c = vc_fdata_i[v*FLIT_W +: FLIT_W];
      end
    end
    gtype_c = flit_type_t'(gflit_c[FLIT_W-1 -: TYPE_W]);
  end

  // Framing: the popped VC moves to the state implied by the flit type; illegal moves flag.
  always_comb begin
    err_d = err_q;
    for (int unsigned v = 0; v < N_VC; v++) begin
      st_d[v] = st_q[v];
      if (vc_ready_o[v]) begin
        if (st_q[v] == VC_IDLE) begin
          if (gtype_c == BODY || gtype_c == TAIL) err_d = 1'b1;
        end else begin
          if (gtype_c == HEAD || gtype_c == SINGLE) err_d = 1'b1;
        end
        st_d[v] = (gtype_c == HEAD || gtype_c == BODY) ? VC_IN_PKT : VC_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      fdata_q  <= '0;
      vc_id_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rr_ptr_q <= PTR_W'(N_VC - 1);
      for (int unsigned v = 0; v < N_VC; v++) st_q[v] <= VC_IDLE;
    end else begin
      if (load_c) begin
        fdata_q  <= gflit_c;
        vc_id_q  <= 2'(gidx_c);
        valid_q  <= 1'b1;
        rr_ptr_q <= gidx_c;
      end else if (accept_c) begin
        valid_q  <= 1'b0;
      end
      err_q <= err_d;
      for (int unsigned v = 0; v < N_VC; v++) st_q[v] <= st_d[v];
    end
  end

  assign fdata_o     = fdata_q;
  assign vc_id_o     = vc_id_q;
  assign valid_o     = valid_q;
  assign proto_err_o = err_q;

endmodule

// File: tb/tb_vc_out_arbiter.sv
// Bench for vc_out_arbiter: directed scenarios plus random traffic against a reference model.
module tb_vc_out_arbiter;
  import noc_pkg::*;

  localparam int unsigned N     = 3;
  localparam int unsigned FW    = noc_pkg::FLIT_W;
  localparam int unsigned DEPTH = 2;

  logic              clk = 1'b0;
  logic              arst;
  logic [N*FW-1:0]   vc_fdata;
  logic [N-1:0]      vc_valid;
  logic [N-1:0]      vc_ready;
  logic [FW-1:0]     fdata;
  logic [1:0]        vc_id;
  logic              valid;
  logic              perr;
  logic              ready;
  logic [N-1:0]      credit;

  always #5 clk = ~clk;

  vc_out_arbiter dut (
    .clk         (clk),
    .arst        (arst),
    .vc_fdata_i  (vc_fdata),
    .vc_valid_i  (vc_valid),
    .vc_ready_o  (vc_ready),
    .fdata_o     (fdata),
    .vc_id_o     (vc_id),
    .valid_o     (valid),
`ifdef VC_OUT_CREDIT_FC_EN
    .credit_i    (credit),
`else
    .ready_i     (ready),
`endif
    .proto_err_o (perr)
  );

  // Reference model state
  logic          m_valid;
  logic [FW-1:0] m_fdata;
  int            m_id;
  logic          m_err;
  int            m_ptr;
  bit            m_inpkt [N];
  int            m_cnt   [N];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_fdata = '0;
    m_id    = 0;
    m_err   = 1'b0;
    m_ptr   = N - 1;
    for (int v = 0; v < N; v++) begin
      m_inpkt[v] = 1'b0;
      m_cnt[v]   = DEPTH;
    end
  endtask

  function automatic bit can_send(input int v);
`ifdef VC_OUT_CREDIT_FC_EN
    return vc_valid[v] && (m_cnt[v] > 0);
`else
    return vc_valid[v];
`endif
  endfunction

  // Next VC after the last winner that may send, or -1.
  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      if (can_send((m_ptr + k) % N)) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive inputs, check pop strobes, advance model, check registered outputs.
  task automatic step(input logic [N-1:0] vv, input logic rdy, input logic [N-1:0] cr,
                      input logic [2*N-1:0] types, output int gnt);
    int            g;
    bit            accept;
    logic [N-1:0]  exp_rdy;
    logic [FW-1:0] f;
    logic [1:0]    t;
    vc_valid = vv;
    ready    = rdy;
    credit   = cr;
    for (int v = 0; v < N; v++) vc_fdata[v*FW +: FW] = {types[2*v +: 2], 32'($urandom())};
    #1;
    g = pick();
`ifdef VC_OUT_CREDIT_FC_EN
    accept = 1'b1;
`else
    accept = !m_valid || rdy;
`endif
    exp_rdy = '0;
    if (accept && g >= 0) exp_rdy[g] = 1'b1;
    chk("vc_ready_o", 64'(vc_ready), 64'(exp_rdy));
    gnt = (accept && g >= 0) ? g : -1;
    if (gnt >= 0) begin
      f = vc_fdata[gnt*FW +: FW];
      t = f[FW-1 -: 2];
      if (m_inpkt[gnt] ? (t == HEAD || t == SINGLE) : (t == BODY || t == TAIL)) m_err = 1'b1;
      m_inpkt[gnt] = (t == HEAD || t == BODY);
      m_fdata = f;
      m_id    = gnt;
      m_valid = 1'b1;
      m_ptr   = gnt;
    end else if (accept) begin
      m_valid = 1'b0;
    end
`ifdef VC_OUT_CREDIT_FC_EN
    for (int v = 0; v < N; v++) begin
      m_cnt[v] = m_cnt[v] - ((gnt == v) ? 1 : 0) + (cr[v] ? 1 : 0);
      if (m_cnt[v] > DEPTH) m_cnt[v] = DEPTH;
    end
`endif
    @(posedge clk);
    #1;
    chk("valid_o", 64'(valid), 64'(m_valid));
    if (m_valid) begin
      chk("fdata_o", 64'(fdata), 64'(m_fdata));
      chk("vc_id_o", 64'(vc_id), 64'(m_id));
    end
    chk("proto_err_o", 64'(perr), 64'(m_err));
  endtask

  initial begin
    int            g;
    int            prev;
    int            sent;
    logic [FW-1:0] held_f;
    logic [1:0]    held_id;

    arst     = 1'b0;
    vc_valid = '0;
    vc_fdata = '0;
    ready    = 1'b0;
    credit   = '0;
    model_reset();
    #12;
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_fdata", 64'(fdata), 64'(0));
    chk("rst_vc_id", 64'(vc_id), 64'(0));
    chk("rst_err",   64'(perr),  64'(0));
    @(posedge clk);
    #1;
    arst = 1'b1;

    // VC1 head/body/tail
    step(3'b010, 1'b1, '0, {3{HEAD}},   g); chk("vc1_head_gnt", 64'(g), 64'(1));
    step(3'b010, 1'b1, '0, {3{BODY}},   g); chk("vc1_body_gnt", 64'(g), 64'(1));
    step(3'b010, 1'b1, '0, {3{TAIL}},   g); chk("vc1_tail_gnt", 64'(g), 64'(1));
    chk("vc1_no_err", 64'(perr), 64'(0));
    step(3'b000, 1'b1, '0, {3{SINGLE}}, g);

    // All VCs busy: strict rotation
    prev = m_ptr;
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 1'b1, '0, {3{SINGLE}}, g);
`ifdef VC_OUT_CREDIT_FC_EN
      if (g >= 0) begin
        chk("rr_order", 64'(g), 64'((prev + 1) % N));
        prev = g;
      end
`else
      chk("rr_order", 64'(g), 64'((prev + 1) % N));
      chk("rr_valid_high", 64'(valid), 64'(1));
      prev = g;
`endif
    end

`ifndef VC_OUT_CREDIT_FC_EN
    // Stall with a flit held
    step(3'b111, 1'b1, '0, {3{SINGLE}}, g);
    held_f  = fdata;
    held_id = vc_id;
    for (int i = 0; i < 4; i++) begin
      step(3'b111, 1'b0, '0, {3{SINGLE}}, g);
      chk("stall_fdata", 64'(fdata), 64'(held_f));
      chk("stall_vc_id", 64'(vc_id), 64'(held_id));
    end
    step(3'b111, 1'b1, '0, {3{SINGLE}}, g);
    chk("stall_next_gnt", 64'(g), 64'((held_id + 1) % N));
`endif

    // Body on idle VC2 flags a sticky error
    step(3'b000, 1'b1, '0, {3{SINGLE}}, g);
    step(3'b000, 1'b1, '0, {3{SINGLE}}, g);
    step(3'b100, 1'b1, '0, {3{BODY}},   g);
    chk("err_vc_id", 64'(vc_id), 64'(2));
    chk("err_set",   64'(perr),  64'(1));
    step(3'b000, 1'b1, '0, {3{SINGLE}}, g);
    step(3'b000, 1'b1, '0, {3{SINGLE}}, g);
    chk("err_sticky", 64'(perr), 64'(1));

    // Asynchronous reset in the middle of a VC0 packet
    step(3'b001, 1'b1, '0, {3{HEAD}}, g);
    #2;
    arst = 1'b0;
    #1;
    chk("arst_valid", 64'(valid), 64'(0));
    chk("arst_err",   64'(perr),  64'(0));
    model_reset();
    @(posedge clk);
    #1;
    arst = 1'b1;
    step(3'b001, 1'b1, '0, {3{HEAD}}, g);
    chk("post_rst_head_gnt", 64'(g), 64'(0));
    chk("post_rst_no_err",   64'(perr), 64'(0));
    step(3'b001, 1'b1, '0, {3{TAIL}}, g);

`ifdef VC_OUT_CREDIT_FC_EN
    // Credit exhaustion and one refill on VC0
    arst = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    arst = 1'b1;
    sent = 0;
    for (int i = 0; i < 5; i++) begin
      step(3'b001, 1'b1, '0, {3{SINGLE}}, g);
      if (g == 0) sent++;
    end
    chk("credit_sent_depth", 64'(sent), 64'(DEPTH));
    sent = 0;
    step(3'b001, 1'b1, 3'b001, {3{SINGLE}}, g);
    if (g == 0) sent++;
    for (int i = 0; i < 4; i++) begin
      step(3'b001, 1'b1, '0, {3{SINGLE}}, g);
      if (g == 0) sent++;
    end
    chk("credit_refill_one", 64'(sent), 64'(1));
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom()), ($urandom_range(0, 3) != 0), N'($urandom()),
           (2*N)'($urandom()), g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
